// File: rtl/usb_pkg.sv
// Shared USB bit-level definitions used by both the bit stuffer and unstuffer.
package usb_pkg;

  localparam int unsigned USB_MAX_ONES = 6;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } unstuff_state_t;

endpackage

// File: rtl/usb_rx_deserializer.sv
// LSB-first bit-to-byte shifter; byte_valid pulses with the eighth accepted bit.
module usb_rx_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    if (clear) begin
      cnt_d   = 3'd0;
      shift_d = 8'h00;
    end else if (bit_valid) begin
      // First received bit ends up in bit 0 after eight right shifts.
      shift_d = {bit_in, shift_q[7:1]};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_d  = shift_d;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;

endmodule

// File: rtl/usb_bit_unstuffer.sv
// Receive-side bit unstuffer: drops the zero stuffed after MAX_ONES ones, flags violations,
// and feeds surviving bits to the byte deserializer.
module usb_bit_unstuffer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_ONES = USB_MAX_ONES
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       in_bit,
  input  logic       en,
  input  logic       clear,
  output logic       out_bit,
  output logic       out_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stuff_err,
  output logic       in_err
);

  localparam int unsigned CntW = $clog2(MAX_ONES + 1);
  localparam logic [CntW-1:0] MaxOnes = CntW'(MAX_ONES);

  unstuff_state_t  state_q, state_d;
  logic [CntW-1:0] ones_q, ones_d;
  logic            out_bit_q, out_bit_d;
  logic            out_valid_q, out_valid_d;
  logic            stuff_err_q, stuff_err_d;
  logic            emit;
  logic            violation;

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    emit        = 1'b0;
    violation   = 1'b0;
    if (clear) begin
      state_d = RUN;
      ones_d  = '0;
    end else if (en && (state_q == RUN)) begin
      if (ones_q == MaxOnes) begin
        // This slot must carry a stuffed zero; a one here is a violation.
        ones_d = '0;
        if (in_bit) begin
          violation   = 1'b1;
          stuff_err_d = 1'b1;
          state_d     = ERR;
        end
      end else begin
        emit        = 1'b1;
        out_valid_d = 1'b1;
        out_bit_d   = in_bit;
        ones_d      = in_bit ? ones_q + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      ones_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  // A violation discards the partially assembled byte.
  usb_rx_deserializer u_deser (
    .clk        (clk),
    .rst        (RST),
    .clear      (clear | violation),
    .bit_valid  (emit),
    .bit_in     (in_bit),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign stuff_err = stuff_err_q;
  assign in_err    = (state_q == ERR);

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Scoreboard bench: a reference stuffer drives the wire and queues the expected data bits/bytes.
module tb_usb_bit_unstuffer;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       in_bit = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       out_bit;
  logic       out_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stuff_err;
  logic       in_err;

  int n_checks = 0;
  int n_fail   = 0;

  bit   exp_bits[$];
  logic [7:0] exp_bytes[$];
  bit   allow_serr = 1'b0;

  // Reference transmitter state
  int         tx_ones = 0;
  int         tx_cnt  = 0;
  logic [7:0] tx_shift = 8'h00;

  usb_bit_unstuffer dut (
    .clk        (clk),
    .RST        (RST),
    .in_bit     (in_bit),
    .en         (en),
    .clear      (clear),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .stuff_err  (stuff_err),
    .in_err     (in_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Monitor: outputs are sampled on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (!RST) begin
      if (out_valid) begin
        n_checks++;
        if (exp_bits.size() == 0) begin
          n_fail++;
          $display("FAIL out_bit_unexpected: got out_valid with bit %0b, expected no strobe",
                   out_bit);
        end else begin
          bit e;
          e = exp_bits.pop_front();
          if (out_bit !== e) begin
            n_fail++;
            $display("FAIL out_bit: got %0b, expected %0b", out_bit, e);
          end
        end
      end
      if (byte_valid) begin
        n_checks++;
        if (exp_bytes.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected: got byte_valid with %02h, expected no strobe",
                   byte_out);
        end else begin
          logic [7:0] eb;
          eb = exp_bytes.pop_front();
          if (byte_out !== eb) begin
            n_fail++;
            $display("FAIL byte_out: got %02h, expected %02h", byte_out, eb);
          end
        end
      end
      if (stuff_err && !allow_serr) begin
        n_checks++;
        n_fail++;
        $display("FAIL stuff_err_unexpected: got 1, expected 0");
      end
    end
  end

  task automatic tx_reset();
    tx_ones  = 0;
    tx_cnt   = 0;
    tx_shift = 8'h00;
  endtask

  task automatic send_raw(input bit b);
    @(negedge clk);
    en     = 1'b1;
    clear  = 1'b0;
    in_bit = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en    = 1'b0;
      clear = 1'b0;
    end
  endtask

  // One data bit through the reference stuffer, with expectations queued.
  task automatic send_data_bit(input bit b);
    exp_bits.push_back(b);
    tx_shift = {b, tx_shift[7:1]};
    tx_cnt++;
    if (tx_cnt == 8) begin
      exp_bytes.push_back(tx_shift);
      tx_cnt = 0;
    end
    send_raw(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      send_raw(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic do_clear();
    @(negedge clk);
    en    = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tx_reset();
  endtask

  task automatic check_drained(input string name);
    idle(3);
    n_checks++;
    if (exp_bits.size() != 0 || exp_bytes.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d bits and %0d bytes outstanding, expected 0 and 0",
               name, exp_bits.size(), exp_bytes.size());
      exp_bits.delete();
      exp_bytes.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({out_bit, out_valid, byte_out, byte_valid, stuff_err, in_err} !== 13'h0) begin
      n_fail++;
      $display("FAIL %s: got out_bit=%0b out_valid=%0b byte_out=%02h byte_valid=%0b stuff_err=%0b in_err=%0b, expected all 0",
               name, out_bit, out_valid, byte_out, byte_valid, stuff_err, in_err);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #12;
    check_idle_outputs("reset_state");
    @(negedge clk);
    RST = 1'b0;
    idle(2);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_ones_stuffed();
    // Seven data ones go out on the wire as 1,1,1,1,1,1,0,1.
    for (int i = 0; i < 7; i++) send_data_bit(1'b1);
    check_drained("ones_stuffed");
    do_clear();
  endtask

  task automatic test_byte_a5();
    send_byte(8'hA5);
    check_drained("byte_a5");
  endtask

  task automatic test_back_to_back();
    // FF leaves a run of two ones that continues into the next byte.
    send_byte(8'hFF);
    send_byte(8'h0F);
    send_byte(8'hFE);
    send_byte(8'h81);
    check_drained("back_to_back");
  endtask

  task automatic test_violation();
    do_clear();
    for (int i = 0; i < 6; i++) begin
      exp_bits.push_back(1'b1);
      send_raw(1'b1);
    end
    allow_serr = 1'b1;
    send_raw(1'b1);
    @(negedge clk);
    en = 1'b0;
    n_checks++;
    if (stuff_err !== 1'b1 || in_err !== 1'b1) begin
      n_fail++;
      $display("FAIL violation_pulse: got stuff_err=%0b in_err=%0b, expected 1 and 1",
               stuff_err, in_err);
    end
    @(negedge clk);
    n_checks++;
    if (stuff_err !== 1'b0 || in_err !== 1'b1) begin
      n_fail++;
      $display("FAIL violation_hold: got stuff_err=%0b in_err=%0b, expected 0 and 1",
               stuff_err, in_err);
    end
    allow_serr = 1'b0;
    for (int i = 0; i < 10; i++) send_raw(i[0]);
    idle(2);
    n_checks++;
    if (in_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got in_err=%0b, expected 1", in_err);
    end
    do_clear();
    @(negedge clk);
    n_checks++;
    if (in_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got in_err=%0b, expected 0", in_err);
    end
    send_byte(8'h3C);
    check_drained("violation");
  endtask

  task automatic test_clear_with_en();
    for (int i = 0; i < 5; i++) send_data_bit(i[0]);
    @(negedge clk);
    en     = 1'b1;
    in_bit = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    en    = 1'b0;
    clear = 1'b0;
    tx_reset();
    send_byte(8'h3C);
    check_drained("clear_with_en");
  endtask

  task automatic test_async_reset();
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_data_bit(1'b1);
    idle(1);
    // Discard the partial-byte expectation; reset wipes it in the DUT too.
    tx_reset();
    @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    RST = 1'b0;
    send_byte(8'h5A);
    check_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_ones_stuffed();
    test_byte_a5();
    test_back_to_back();
    test_violation();
    test_clear_with_en();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
